// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and saturation helper for the saturating shift-add ALU
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MAC = 3'd2;
    localparam logic [2:0] OP_LDA = 3'd3;
    localparam logic [2:0] OP_ASR = 3'd4;

    // Wide enough for WIDTH + 2**SHIFT_W + 1 at the default 16/5 configuration.
    localparam int CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    // Returns {sat, clipped value}; the clipped value is sign-extended to CALC_W.
    function automatic logic [CALC_W:0] sat_clip(input calc_t value, input int width);
        calc_t max_v;
        calc_t min_v;
        max_v = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
        min_v = -max_v - calc_t'(1);
        if (value > max_v) begin
            return {1'b1, max_v};
        end else if (value < min_v) begin
            return {1'b1, min_v};
        end
        return {1'b0, value};
    endfunction

endpackage

// File: rtl/alu_sat_stage.sv
// rtl/alu_sat_stage.sv - combinational second-stage datapath: add/sub/accumulate select and saturation
module alu_sat_stage #(
    parameter int WIDTH   = 16,
    parameter int SHIFT_W = 5,
    parameter int IW      = WIDTH + 2**SHIFT_W + 1
) (
    input  logic        [2:0]         op,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    input  logic signed [WIDTH-1:0]   acc,
    input  logic        [SHIFT_W-1:0] sh,
    input  logic signed [IW-1:0]      a_shl,
    output logic signed [WIDTH-1:0]   y,
    output logic                      sat,
    output logic                      acc_we
);
    import alu_pkg::*;

    calc_t             sum_c;
    logic [CALC_W:0]   clip_c;
    logic              unused_clip_hi;

    always_comb begin
        sum_c = '0;
        case (op)
            OP_ADD:  sum_c = calc_t'(a_shl) + calc_t'(b);
            OP_SUB:  sum_c = calc_t'(a_shl) - calc_t'(b);
            OP_MAC:  sum_c = calc_t'(acc) + calc_t'(a_shl);
            default: sum_c = '0;
        endcase
    end

    assign clip_c         = sat_clip(sum_c, WIDTH);
    assign unused_clip_hi = ^clip_c[CALC_W-1:WIDTH];

    always_comb begin
        y      = b;
        sat    = 1'b0;
        acc_we = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                y   = clip_c[WIDTH-1:0];
                sat = clip_c[CALC_W];
            end
            OP_MAC: begin
                y      = clip_c[WIDTH-1:0];
                sat    = clip_c[CALC_W];
                acc_we = 1'b1;
            end
            OP_LDA:  acc_we = 1'b1;
            OP_ASR:  y = a >>> sh;
            default: y = b;
        endcase
    end

endmodule

// File: rtl/alu_sat_pipe.sv
// rtl/alu_sat_pipe.sv - two-stage saturating shift-add/MAC ALU with valid/ready handshakes
module alu_sat_pipe #(
    parameter int WIDTH   = 16,
    parameter int SHIFT_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic        [2:0]         in_op,
    input  logic signed [WIDTH-1:0]   in_a,
    input  logic signed [WIDTH-1:0]   in_b,
    input  logic        [SHIFT_W-1:0] in_shift,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH-1:0]   out_y,
    output logic                      out_sat,
    output logic                      sat_sticky,
    input  logic                      sat_clr
);
    import alu_pkg::*;

    localparam int IW = WIDTH + 2**SHIFT_W + 1;

    logic                      s1_valid_q, s1_valid_d;
    logic        [2:0]         s1_op_q, s1_op_d;
    logic signed [WIDTH-1:0]   s1_a_q, s1_a_d;
    logic signed [WIDTH-1:0]   s1_b_q, s1_b_d;
    logic        [SHIFT_W-1:0] s1_sh_q, s1_sh_d;
    logic signed [IW-1:0]      s1_ashl_q, s1_ashl_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0]   out_y_q, out_y_d;
    logic                      out_sat_q, out_sat_d;
    logic signed [WIDTH-1:0]   acc_q, acc_d;
    logic                      sticky_q, sticky_d;

    logic                      s2_advance;
    logic                      s2_load;
    logic signed [IW-1:0]      a_ext;
    logic signed [WIDTH-1:0]   stage_y;
    logic                      stage_sat;
    logic                      stage_acc_we;

    alu_sat_stage #(
        .WIDTH   (WIDTH),
        .SHIFT_W (SHIFT_W),
        .IW      (IW)
    ) u_stage (
        .op     (s1_op_q),
        .a      (s1_a_q),
        .b      (s1_b_q),
        .acc    (acc_q),
        .sh     (s1_sh_q),
        .a_shl  (s1_ashl_q),
        .y      (stage_y),
        .sat    (stage_sat),
        .acc_we (stage_acc_we)
    );

    assign a_ext = IW'(in_a);

    always_comb begin
        s2_advance  = !out_valid_q || out_ready;
        in_ready    = !s1_valid_q || s2_advance;
        s2_load     = s1_valid_q && s2_advance;

        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_sh_d     = s1_sh_q;
        s1_ashl_d   = s1_ashl_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_sat_d   = out_sat_q;
        acc_d       = acc_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d   = in_op;
                s1_a_d    = in_a;
                s1_b_d    = in_b;
                s1_sh_d   = in_shift;
                // Exact shift: the intermediate is wide enough that nothing wraps.
                s1_ashl_d = a_ext <<< in_shift;
            end
        end

        if (s2_advance) begin
            out_valid_d = s1_valid_q;
        end

        // acc moves only with the beat entering S2, so a stalled beat updates it once.
        if (s2_load) begin
            out_y_d   = stage_y;
            out_sat_d = stage_sat;
            if (stage_acc_we) begin
                acc_d = stage_y;
            end
        end

        sticky_d = (sticky_q && !sat_clr) || (s2_load && stage_sat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_sh_q     <= '0;
            s1_ashl_q   <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_sat_q   <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_sh_q     <= s1_sh_d;
            s1_ashl_q   <= s1_ashl_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_sat_q   <= out_sat_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_y      = out_y_q;
    assign out_sat    = out_sat_q;
    assign sat_sticky = sticky_q;

endmodule

// File: tb/tb_alu_sat_pipe.sv
// tb/tb_alu_sat_pipe.sv - self-checking bench for alu_sat_pipe against an integer reference model
module tb_alu_sat_pipe;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic        [2:0]  in_op = '0;
    logic signed [15:0] in_a = '0;
    logic signed [15:0] in_b = '0;
    logic        [4:0]  in_shift = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_y;
    logic               out_sat;
    logic               sat_sticky;
    logic               sat_clr = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    alu_sat_pipe #(.WIDTH(16), .SHIFT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_shift   (in_shift),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_sat    (out_sat),
        .sat_sticky (sat_sticky),
        .sat_clr    (sat_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: plain integer arithmetic, then clip.
    longint             model_acc = 0;
    logic signed [15:0] exp_y[$];
    logic               exp_s[$];
    logic signed [15:0] obs_y[$];
    logic               obs_s[$];

    function automatic void model_beat(input logic [2:0] op, input logic signed [15:0] a,
                                       input logic signed [15:0] b, input logic [4:0] sh);
        longint ashl, r, c;
        logic   s;
        ashl = longint'(a) * (longint'(1) << sh);
        case (op)
            3'd0:    r = ashl + longint'(b);
            3'd1:    r = ashl - longint'(b);
            3'd2:    r = model_acc + ashl;
            3'd4:    r = longint'(a) >>> sh;
            default: r = longint'(b);
        endcase
        s = (r > 32767) || (r < -32768);
        c = (r > 32767) ? 32767 : ((r < -32768) ? -32768 : r);
        if (op == 3'd2 || op == 3'd3) model_acc = c;
        exp_y.push_back(c[15:0]);
        exp_s.push_back(s);
    endfunction

    logic               stall_prev = 1'b0;
    logic signed [15:0] held_y;
    logic               held_s;

    always @(negedge clk) begin
        if (rst) begin
            exp_y.delete();
            exp_s.delete();
            model_acc  = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", longint'(out_valid), 1);
                chk("stall_y", longint'(out_y), longint'(held_y));
                chk("stall_sat", longint'(out_sat), longint'(held_s));
            end
            if (out_valid) chk("y_not_x", longint'($isunknown(out_y)), 0);
            if (out_valid && out_ready) begin
                if (exp_y.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    chk("model_y", longint'(out_y), longint'(exp_y.pop_front()));
                    chk("model_sat", longint'(out_sat), longint'(exp_s.pop_front()));
                end
                obs_y.push_back(out_y);
                obs_s.push_back(out_sat);
            end
            if (in_valid && in_ready) model_beat(in_op, in_a, in_b, in_shift);
            stall_prev = out_valid && !out_ready;
            held_y     = out_y;
            held_s     = out_sat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic signed [15:0] a,
                        input logic signed [15:0] b, input logic [4:0] sh);
        bit got;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_shift = sh;
        got      = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            tick();
        end
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic clear_obs();
        obs_y.delete();
        obs_s.delete();
    endtask

    task automatic chk_obs(input string name, input int idx, input longint y, input longint s);
        if (obs_y.size() <= idx) begin
            chk({name, "_missing"}, obs_y.size(), idx + 1);
        end else begin
            chk({name, "_y"}, longint'(obs_y[idx]), y);
            chk({name, "_sat"}, longint'(obs_s[idx]), s);
        end
    endtask

    bit done;

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_sticky", sat_sticky, 0);
        chk("rst_in_ready", in_ready, 1);

        // Latency: presented before edge 1, visible after edge 2.
        send(3'd0, 16'sd3, 16'sd5, 5'd2);
        idle();
        chk("lat_not_yet", out_valid, 0);
        tick();
        chk("lat_valid", out_valid, 1);
        chk("add_y", out_y, 17);
        chk("add_sat", out_sat, 0);
        tick();

        // Saturation and sticky flag.
        send(3'd0, 16'sd16384, 16'sd1, 5'd1);
        idle();
        tick();
        chk("addsat_y", out_y, 32767);
        chk("addsat_sat", out_sat, 1);
        chk("sticky_set", sat_sticky, 1);
        tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("sticky_clr", sat_sticky, 0);
        send(3'd0, 16'sd16384, 16'sd1, 5'd1);
        idle();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("sticky_set_wins", sat_sticky, 1);
        chk("sticky_set_wins_sat", out_sat, 1);
        tick();

        // SUB saturating low, ASR of most-negative value.
        clear_obs();
        send(3'd1, -16'sd1, 16'sd32767, 5'd15);
        send(3'd4, -16'sd32768, 16'sd0, 5'd31);
        idle();
        repeat (4) tick();
        chk_obs("sub", 0, -32768, 1);
        chk_obs("asr", 1, -1, 0);

        // LDA then chained MACs, then MAC clipping.
        clear_obs();
        send(3'd3, 16'sd0, 16'sd100, 5'd0);
        send(3'd2, 16'sd1, 16'sd0, 5'd3);
        send(3'd2, 16'sd1, 16'sd0, 5'd3);
        send(3'd2, 16'sd1, 16'sd0, 5'd3);
        send(3'd2, 16'sd16383, 16'sd0, 5'd1);
        send(3'd2, 16'sd16383, 16'sd0, 5'd1);
        idle();
        repeat (4) tick();
        chk_obs("lda", 0, 100, 0);
        chk_obs("mac1", 1, 108, 0);
        chk_obs("mac2", 2, 116, 0);
        chk_obs("mac3", 3, 124, 0);
        chk_obs("macsat1", 4, 32767, 1);
        chk_obs("macsat2", 5, 32767, 1);

        // Back-pressure: consumer stalls for 5 cycles while 4 beats stream in.
        clear_obs();
        out_ready = 1'b0;
        fork
            begin
                send(3'd3, 16'sd0, 16'sd10, 5'd0);
                send(3'd2, 16'sd1, 16'sd0, 5'd0);
                send(3'd2, 16'sd2, 16'sd0, 5'd1);
                send(3'd0, 16'sd5, 16'sd6, 5'd0);
                idle();
            end
            begin
                repeat (4) tick();
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_held_y", out_y, 10);
                tick();
                out_ready = 1'b1;
            end
        join
        repeat (4) tick();
        chk("bp_count", obs_y.size(), 4);
        chk_obs("bp0", 0, 10, 0);
        chk_obs("bp1", 1, 11, 0);
        chk_obs("bp2", 2, 15, 0);
        chk_obs("bp3", 3, 11, 0);

        // Reset with two beats in flight.
        out_ready = 1'b0;
        send(3'd0, 16'sd7, 16'sd1, 5'd0);
        send(3'd2, 16'sd3, 16'sd0, 5'd0);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rrst_out_valid", out_valid, 0);
        chk("rrst_in_ready", in_ready, 1);
        chk("rrst_acc", longint'(dut.acc_q), 0);
        out_ready = 1'b1;
        clear_obs();
        tick();
        chk("rrst_no_output", obs_y.size(), 0);
        send(3'd0, 16'sd1, 16'sd1, 5'd0);
        send(3'd2, 16'sd5, 16'sd0, 5'd0);
        idle();
        repeat (4) tick();
        chk_obs("post_rst_add", 0, 2, 0);
        chk_obs("post_rst_mac", 1, 5, 0);

        // Random sweep with random consumer back-pressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic signed [15:0] ra, rb;
                    logic [4:0]         rs;
                    case ($urandom_range(0, 3))
                        0: ra = 16'($urandom);
                        1: ra = 16'($signed($urandom_range(0, 16)) - 8);
                        2: ra = $urandom_range(0, 1) ? 16'sd32767 : -16'sd32768;
                        default: ra = 16'sd0;
                    endcase
                    rb = $urandom_range(0, 3) == 0 ? 16'sd32767 : 16'($urandom);
                    rs = $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
                    send(3'($urandom_range(0, 7)), ra, rb, rs);
                    if ($urandom_range(0, 4) == 0) begin
                        idle();
                        tick();
                    end
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        repeat (6) tick();
        chk("sweep_drained", exp_y.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
